// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial pattern detector with a runtime-loadable pattern and per-bit
//   don't-care mask. Accepted bits shift into a history register; a match is
//   declared when the newest PAT_W bits (history plus the bit arriving this
//   cycle) agree with the pattern on every masked-in position.
//
// Parameters
//   PAT_W    pattern length in bits (2..32)
//   PATTERN  pattern loaded by reset (MSB = oldest bit)
//   OVERLAP  1: a bit may belong to consecutive matches; 0: a match restarts fill
//   CNT_W    width of the saturating match counter
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   en           din valid this cycle
//   din          serial data bit
//   cfg_we       load cfg_pattern / cfg_mask, restart fill (wins over en)
//   cfg_pattern  new pattern, MSB oldest
//   cfg_mask     per-bit compare enable (1 = compare)
//   cnt_clr      clear match_cnt (to 1 if a hit coincides)
//   match        registered one-cycle pulse per detection
//   match_cnt    saturating detection count
//   armed        registered; next valid bit can complete a match
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  // Fill counts 0..PAT_W, so it needs room for PAT_W itself.
  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  hist_reg, hist_next;
  logic [PAT_W-1:0]  pat_reg, pat_next;
  logic [PAT_W-1:0]  mask_reg, mask_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              match_reg;
  logic              armed_reg;

  logic [PAT_W-1:0]  candidate;
  logic [PAT_W-1:0]  diff_bits;
  logic              accept;
  logic              hit;

  // The bit arriving this cycle completes the candidate, so a match is
  // recognised on the same edge that samples the final bit.
  assign candidate = {hist_reg[PAT_W-2:0], din};

  // A position disagrees only if it differs from the pattern and is masked in.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
      assign diff_bits[gi] = (candidate[gi] ^ pat_reg[gi]) & mask_reg[gi];
    end
  endgenerate

  // A configuration write swallows any bit presented in the same cycle.
  assign accept = en & ~cfg_we;
  assign hit    = accept & (fill_reg >= FILL_ARM) & ~(|diff_bits);

  always_comb begin
    hist_next = hist_reg;
    pat_next  = pat_reg;
    mask_next = mask_reg;
    fill_next = fill_reg;
    cnt_next  = cnt_reg;

    if (cfg_we) begin
      // History is kept; with fill back at 0 the stale bits age out before
      // they can take part in a comparison.
      pat_next  = cfg_pattern;
      mask_next = cfg_mask;
      fill_next = '0;
    end else if (en) begin
      hist_next = candidate;
      if (hit && !OVERLAP) begin
        fill_next = '0;
      end else if (fill_reg != FILL_FULL) begin
        fill_next = fill_reg + 1'b1;
      end
    end

    // Clear and hit together leave the count at one: the hit is not lost.
    if (cnt_clr) begin
      cnt_next = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg  <= '0;
      pat_reg   <= PATTERN;
      mask_reg  <= '1;
      fill_reg  <= '0;
      cnt_reg   <= '0;
      match_reg <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      hist_reg  <= hist_next;
      pat_reg   <= pat_next;
      mask_reg  <= mask_next;
      fill_reg  <= fill_next;
      cnt_reg   <= cnt_next;
      match_reg <= hit;
      armed_reg <= (fill_next >= FILL_ARM);
    end
  end

  assign match     = match_reg;
  assign match_cnt = cnt_reg;
  assign armed     = armed_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param. Three instances share one input stream:
//   u0 default parameters, u1 OVERLAP=0, u2 CNT_W=2.
// Expected outputs come from a reference model that tracks, per instance,
// how many fresh bits have arrived since the last restart and the value of
// the newest three of them as an integer.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic [3:0] cfg_mask = 4'b0000;
  logic       cnt_clr = 1'b0;

  logic       match0, match1, match2;
  logic       armed0, armed1, armed2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detect_param u0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
    .match(match0), .match_cnt(cnt0), .armed(armed0)
  );

  seq_detect_param #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
    .match(match1), .match_cnt(cnt1), .armed(armed1)
  );

  seq_detect_param #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
    .match(match2), .match_cnt(cnt2), .armed(armed2)
  );

  // Reference model state
  int m_n[3];      // fresh accepted bits since last restart (capped at 4)
  int m_win[3];    // newest up-to-3 fresh bits as an integer
  int m_pat[3];
  int m_mask[3];
  int m_cnt[3];
  int m_match[3];
  int m_armed[3];
  int ovl[3]  = '{1, 0, 1};
  int cmax[3] = '{255, 255, 3};

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int step_no   = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d (step %0d)", tag, obs, expv, step_no);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit d, input bit w,
                              input logic [3:0] cp, input logic [3:0] cm, input bit c);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_n[i] = 0; m_win[i] = 0; m_pat[i] = 11; m_mask[i] = 15;
        m_cnt[i] = 0; m_match[i] = 0; m_armed[i] = 0;
      end else begin
        int  cand;
        bit  h;
        cand = m_win[i] * 2 + int'(d);
        h = e && !w && (m_n[i] >= 3) && (((cand ^ m_pat[i]) & m_mask[i]) == 0);
        if (c) m_cnt[i] = h ? 1 : 0;
        else if (h && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
        if (w) begin
          m_pat[i] = int'(cp); m_mask[i] = int'(cm); m_n[i] = 0; m_win[i] = 0;
        end else if (e) begin
          if (h && ovl[i] == 0) begin
            m_n[i] = 0; m_win[i] = 0;
          end else begin
            m_win[i] = cand % 8;
            if (m_n[i] < 4) m_n[i] = m_n[i] + 1;
          end
        end
        m_match[i] = h ? 1 : 0;
        m_armed[i] = (m_n[i] >= 3) ? 1 : 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit d, input bit w,
                      input logic [3:0] cp, input logic [3:0] cm, input bit c);
    rst = r; en = e; din = d; cfg_we = w; cfg_pattern = cp; cfg_mask = cm; cnt_clr = c;
    model_update(r, e, d, w, cp, cm, c);
    @(posedge clk);
    #1;
    step_no++;
    chk("u0.match", int'(match0), m_match[0]);
    chk("u0.cnt",   int'(cnt0),   m_cnt[0]);
    chk("u0.armed", int'(armed0), m_armed[0]);
    chk("u1.match", int'(match1), m_match[1]);
    chk("u1.cnt",   int'(cnt1),   m_cnt[1]);
    chk("u1.armed", int'(armed1), m_armed[1]);
    chk("u2.match", int'(match2), m_match[2]);
    chk("u2.cnt",   int'(cnt2),   m_cnt[2]);
    chk("u2.armed", int'(armed2), m_armed[2]);
    $display("step %0d rst=%b en=%b din=%b we=%b clr=%b | match=%b%b%b cnt=%0d/%0d/%0d armed=%b%b%b",
             step_no, r, e, d, w, c, match0, match1, match2, cnt0, cnt1, cnt2,
             armed0, armed1, armed2);
  endtask

  task automatic bit_in(input bit d);
    step(1'b0, 1'b1, d, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 1'b1);
  endtask

  initial begin
    logic [6:0]  s7;
    logic [15:0] s16;

    // Reset, with every other control asserted to show reset wins
    do_reset();
    do_reset();
    chk("rst_match", int'(match0), 0);
    chk("rst_cnt",   int'(cnt0),   0);
    chk("rst_armed", int'(armed0), 0);

    // Overlapping vs non-overlapping on 1011011
    s7 = 7'b1011011;
    for (int k = 0; k < 7; k++) begin
      bit_in(s7[6-k]);
      if (k == 3) begin
        chk("ex_ovl_m4",   int'(match0), 1);
        chk("ex_novl_m4",  int'(match1), 1);
        chk("ex_novl_arm", int'(armed1), 0);
      end
    end
    chk("ex_ovl_m7",    int'(match0), 1);
    chk("ex_ovl_cnt",   int'(cnt0),   2);
    chk("ex_novl_m7",   int'(match1), 0);
    chk("ex_novl_cnt",  int'(cnt1),   1);

    // Gaps between valid bits are transparent
    do_reset();
    bit_in(1'b1); idle(); bit_in(1'b0); idle(); idle(); bit_in(1'b1); idle();
    chk("gap_nomatch", int'(match0), 0);
    bit_in(1'b1);
    chk("gap_match", int'(match0), 1);

    // Config write with a same-cycle bit that must be discarded
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1001, 4'b1001, 1'b0);
    chk("cfg_arm0", int'(armed0), 0);
    bit_in(1'b1); bit_in(1'b1);
    chk("cfg_arm2", int'(armed0), 0);
    bit_in(1'b0);
    chk("cfg_arm3", int'(armed0), 1);
    bit_in(1'b1);
    chk("cfg_match", int'(match0), 1);

    // Reset discards a partial sequence
    do_reset();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    do_reset();
    chk("prst_match", int'(match0), 0);
    chk("prst_armed", int'(armed0), 0);
    chk("prst_cnt",   int'(cnt0),   0);
    bit_in(1'b1);
    chk("prst_nomatch", int'(match0), 0);

    // Counter saturation at CNT_W=2 and clear coincident with a hit
    do_reset();
    s16 = 16'b1011011011011011;
    for (int k = 0; k < 16; k++) bit_in(s16[15-k]);
    chk("sat_cnt0", int'(cnt0), 5);
    chk("sat_cnt2", int'(cnt2), 3);
    bit_in(1'b0); bit_in(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("clr_hit_cnt0", int'(cnt0), 1);
    chk("clr_hit_cnt2", int'(cnt2), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("clr_cnt0", int'(cnt0), 0);

    // All-zero mask: every bit after three fresh ones hits
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 4'b0000, 1'b0);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
    chk("m0_nohit", int'(match0), 0);
    bit_in(1'b0);
    chk("m0_hit4", int'(match0), 1);
    bit_in(1'b1);
    chk("m0_hit5", int'(match0), 1);

    // Randomised traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bit         r, e, d, w, c;
      logic [3:0] cp, cm;
      r  = ($urandom_range(0, 99) == 0);
      w  = ($urandom_range(0, 99) < 3);
      c  = ($urandom_range(0, 99) < 3);
      e  = ($urandom_range(0, 99) < 70);
      d  = 1'($urandom);
      cp = 4'($urandom);
      cm = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      step(r, e, d, w, cp, cm, c);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
